// File: rtl/sdpb_arb_if.sv
// Bus bundle between two requesters, the sdpb_arb arbiter and an 8x32
// dual-port RAM. The master side is the requesters plus the RAM;
// the slave side is the arbiter.
interface sdpb_arb_if;
    // requester 0
    logic        r0_req;
    logic        r0_we;
    logic [2:0]  r0_addr;
    logic [31:0] r0_wdata;
    logic [3:0]  r0_wstrb;
    logic        r0_gnt;
    logic        r0_rvalid;
    logic [31:0] r0_rdata;
    // requester 1
    logic        r1_req;
    logic        r1_we;
    logic [2:0]  r1_addr;
    logic [31:0] r1_wdata;
    logic [3:0]  r1_wstrb;
    logic        r1_gnt;
    logic        r1_rvalid;
    logic [31:0] r1_rdata;
    // RAM write port
    logic        ram_cea;
    logic [2:0]  ram_ada;
    logic [31:0] ram_din;
    logic [3:0]  ram_byte_ena;
    // RAM read port
    logic        ram_ceb;
    logic [2:0]  ram_adb;
    logic        ram_oce;
    logic        ram_reset;
    logic [31:0] ram_dout;

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata, r0_wstrb,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata, r1_wstrb,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  ram_cea, ram_ada, ram_din, ram_byte_ena,
        input  ram_ceb, ram_adb, ram_oce, ram_reset,
        output ram_dout
    );

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata, r0_wstrb,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata, r1_wstrb,
        output r1_gnt, r1_rvalid, r1_rdata,
        output ram_cea, ram_ada, ram_din, ram_byte_ena,
        output ram_ceb, ram_adb, ram_oce, ram_reset,
        input  ram_dout
    );
endinterface

// File: rtl/sdpb_arb.sv
// Two-requester arbiter in front of an 8x32 simple dual-port RAM.
// Writes go to port A, reads to port B; one write and one read can issue
// in the same cycle unless they target the same word, in which case the
// write goes first and the read retries. Same-type contention is settled
// by a priority bit that hands the next contention to the loser.
module sdpb_arb (
    input  logic        clk,
    input  logic        reset,
    sdpb_arb_if.slave   bus
);

    logic [1:0] wr_req_s;     // bit N: requester N wants a write
    logic [1:0] rd_req_s;     // bit N: requester N wants a read
    logic [1:0] wr_gnt_s;     // one-hot write grant
    logic [1:0] rd_sel_s;     // one-hot read winner before collision check
    logic [1:0] rd_gnt_s;     // one-hot read grant
    logic       wr_idx_s;
    logic       rd_idx_s;
    logic       contended_s;
    logic       winner_s;

    logic       prio_r;       // requester that wins the next same-type contention
    logic       rvalid_r;     // a read was granted last cycle
    logic       rvalid_idx_r; // which requester that read belongs to

    assign wr_req_s = {bus.r1_req &  bus.r1_we, bus.r0_req &  bus.r0_we};
    assign rd_req_s = {bus.r1_req & ~bus.r1_we, bus.r0_req & ~bus.r0_we};

    // Pick one writer and one reader, then drop the read on an address clash.
    always_comb begin
        wr_gnt_s = 2'b00;
        rd_sel_s = 2'b00;
        rd_gnt_s = 2'b00;
        if (reset) begin
            wr_gnt_s = 2'b00;
            rd_gnt_s = 2'b00;
        end else begin
            case (wr_req_s)
                2'b01:   wr_gnt_s = 2'b01;
                2'b10:   wr_gnt_s = 2'b10;
                2'b11:   wr_gnt_s = prio_r ? 2'b10 : 2'b01;
                default: wr_gnt_s = 2'b00;
            endcase
            case (rd_req_s)
                2'b01:   rd_sel_s = 2'b01;
                2'b10:   rd_sel_s = 2'b10;
                2'b11:   rd_sel_s = prio_r ? 2'b10 : 2'b01;
                default: rd_sel_s = 2'b00;
            endcase
            // Mixed traffic means one writer and one reader on different ports.
            if ((wr_gnt_s != 2'b00) && (rd_sel_s != 2'b00) && (bus.r0_addr == bus.r1_addr)) begin
                rd_gnt_s = 2'b00;
            end else begin
                rd_gnt_s = rd_sel_s;
            end
        end
    end

    assign wr_idx_s    = wr_gnt_s[1];
    assign rd_idx_s    = rd_gnt_s[1];
    assign contended_s = (wr_req_s == 2'b11) || (rd_req_s == 2'b11);
    assign winner_s    = (wr_req_s == 2'b11) ? wr_gnt_s[1] : rd_gnt_s[1];

    assign bus.r0_gnt = wr_gnt_s[0] | rd_gnt_s[0];
    assign bus.r1_gnt = wr_gnt_s[1] | rd_gnt_s[1];

    assign bus.ram_cea      = |wr_gnt_s;
    assign bus.ram_ada      = wr_idx_s ? bus.r1_addr  : bus.r0_addr;
    assign bus.ram_din      = wr_idx_s ? bus.r1_wdata : bus.r0_wdata;
    assign bus.ram_byte_ena = (|wr_gnt_s) ? (wr_idx_s ? bus.r1_wstrb : bus.r0_wstrb) : 4'b0000;

    assign bus.ram_ceb   = |rd_gnt_s;
    assign bus.ram_adb   = rd_idx_s ? bus.r1_addr : bus.r0_addr;
    assign bus.ram_oce   = 1'b1;
    assign bus.ram_reset = reset;

    // A read granted just before reset must not surface while reset is high.
    assign bus.r0_rvalid = rvalid_r & ~rvalid_idx_r & ~reset;
    assign bus.r1_rvalid = rvalid_r &  rvalid_idx_r & ~reset;
    assign bus.r0_rdata  = bus.ram_dout;
    assign bus.r1_rdata  = bus.ram_dout;

    // Priority hand-over after contention and read-return tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_r       <= 1'b0;
            rvalid_r     <= 1'b0;
            rvalid_idx_r <= 1'b0;
        end else begin
            if (contended_s) begin
                prio_r <= ~winner_s;
            end else begin
                prio_r <= prio_r;
            end
            rvalid_r     <= |rd_gnt_s;
            rvalid_idx_r <= rd_idx_s;
        end
    end

endmodule

// File: tb/tb_sdpb_arb.sv
// Randomized bench for sdpb_arb: requesters obey the hold-until-grant rule,
// a behavioural RAM sits on the RAM ports, and a transaction-level model
// predicts grants, RAM port controls and returned read data each cycle.
module tb_sdpb_arb;

    logic clk;
    logic rst_in;

    sdpb_arb_if bus ();

    sdpb_arb dut (
        .clk   (clk),
        .reset (rst_in),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8x32 RAM with byte-enabled write port and registered read.
    bit [31:0] ram_mem [8];
    always @(posedge clk) begin
        if (bus.ram_cea) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_byte_ena[b]) ram_mem[bus.ram_ada][8*b +: 8] <= bus.ram_din[8*b +: 8];
            end
        end
        if (bus.ram_ceb) bus.ram_dout <= ram_mem[bus.ram_adb];
    end

    // Requester stimulus state
    bit        req   [2];
    bit        we    [2];
    bit [2:0]  addr  [2];
    bit [31:0] wdata [2];
    bit [3:0]  wstrb [2];
    bit        gnt_last [2];

    // Reference model state
    bit [31:0] mem_m [8];
    int        prio_m;
    bit        pv_m;
    int        pidx_m;
    bit [31:0] pdata_m;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic set_req(input int i, input bit r, input bit w, input int a,
                           input bit [31:0] d, input bit [3:0] s);
        req[i] = r; we[i] = w; addr[i] = 3'(a); wdata[i] = d; wstrb[i] = s;
    endtask

    task automatic idle_all();
        req[0] = 1'b0;
        req[1] = 1'b0;
    endtask

    // One clock: drive, predict and compare mid-cycle, then advance the model.
    task automatic run_cycle();
        int  ww;
        int  rr;
        int  wn;
        int  rn;
        bit  eg [2];
        bit [3:0] be;
        bus.r0_req = req[0]; bus.r0_we = we[0]; bus.r0_addr = addr[0];
        bus.r0_wdata = wdata[0]; bus.r0_wstrb = wstrb[0];
        bus.r1_req = req[1]; bus.r1_we = we[1]; bus.r1_addr = addr[1];
        bus.r1_wdata = wdata[1]; bus.r1_wstrb = wstrb[1];
        @(negedge clk);
        ww = -1; rr = -1; wn = 0; rn = 0;
        for (int i = 0; i < 2; i++) begin
            if (req[i] && we[i])  wn++;
            if (req[i] && !we[i]) rn++;
        end
        if (!rst_in) begin
            for (int i = 0; i < 2; i++) begin
                if (req[i] && we[i])  ww = (ww < 0) ? i : prio_m;
                if (req[i] && !we[i]) rr = (rr < 0) ? i : prio_m;
            end
            if (ww >= 0 && rr >= 0 && addr[ww] == addr[rr]) rr = -1;
        end
        for (int i = 0; i < 2; i++) eg[i] = (i == ww) || (i == rr);
        be = (ww >= 0) ? wstrb[ww] : 4'b0000;

        chk("r0_gnt", 64'(bus.r0_gnt), 64'(eg[0]));
        chk("r1_gnt", 64'(bus.r1_gnt), 64'(eg[1]));
        chk("ram_cea", 64'(bus.ram_cea), 64'(ww >= 0));
        chk("ram_byte_ena", 64'(bus.ram_byte_ena), 64'(be));
        if (ww >= 0) begin
            chk("ram_ada", 64'(bus.ram_ada), 64'(addr[ww]));
            chk("ram_din", 64'(bus.ram_din), 64'(wdata[ww]));
        end
        chk("ram_ceb", 64'(bus.ram_ceb), 64'(rr >= 0));
        if (rr >= 0) chk("ram_adb", 64'(bus.ram_adb), 64'(addr[rr]));
        chk("r0_rvalid", 64'(bus.r0_rvalid), 64'(!rst_in && pv_m && pidx_m == 0));
        chk("r1_rvalid", 64'(bus.r1_rvalid), 64'(!rst_in && pv_m && pidx_m == 1));
        if (!rst_in && pv_m) begin
            if (pidx_m == 0) chk("r0_rdata", 64'(bus.r0_rdata), 64'(pdata_m));
            else             chk("r1_rdata", 64'(bus.r1_rdata), 64'(pdata_m));
        end
        chk("ram_oce", 64'(bus.ram_oce), 64'd1);
        chk("ram_reset", 64'(bus.ram_reset), 64'(rst_in));

        @(posedge clk);
        if (rst_in) begin
            prio_m = 0;
            pv_m   = 1'b0;
        end else begin
            pv_m = (rr >= 0);
            if (rr >= 0) begin
                pidx_m  = rr;
                pdata_m = mem_m[addr[rr]];
            end
            if (ww >= 0) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[ww][b]) mem_m[addr[ww]][8*b +: 8] = wdata[ww][8*b +: 8];
                end
            end
            if (wn == 2)      prio_m = 1 - ww;
            else if (rn == 2) prio_m = 1 - rr;
        end
        gnt_last[0] = eg[0];
        gnt_last[1] = eg[1];
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        prio_m = 0; pv_m = 1'b0; pidx_m = 0; pdata_m = 32'h0;
        idle_all();
        rst_in = 1'b1;
        @(posedge clk); #1;
        run_cycle();
        run_cycle();
        rst_in = 1'b0;

        // Write then read back
        set_req(0, 1'b1, 1'b1, 3, 32'hDEADBEEF, 4'b1111); run_cycle();
        set_req(0, 1'b1, 1'b0, 3, 32'h0, 4'b0000);        run_cycle();
        idle_all();                                         run_cycle();

        // Byte-masked write, plus a zero-strobe write that must not change data
        set_req(0, 1'b1, 1'b1, 5, 32'h11223344, 4'b1111); run_cycle();
        set_req(0, 1'b1, 1'b1, 5, 32'hAABBCCDD, 4'b0101); run_cycle();
        set_req(0, 1'b1, 1'b1, 5, 32'hFFFFFFFF, 4'b0000); run_cycle();
        set_req(0, 1'b1, 1'b0, 5, 32'h0, 4'b0000);        run_cycle();
        idle_all();                                         run_cycle();

        // Same-type contention from a fresh reset: r0, r1, r0, r1
        rst_in = 1'b1; run_cycle(); rst_in = 1'b0;
        set_req(0, 1'b1, 1'b0, 5, 32'h0, 4'b0000);
        set_req(1, 1'b1, 1'b0, 3, 32'h0, 4'b0000);
        repeat (4) run_cycle();
        idle_all(); run_cycle();

        // Dual issue
        set_req(0, 1'b1, 1'b1, 2, 32'hCAFEF00D, 4'b1111);
        set_req(1, 1'b1, 1'b0, 6, 32'h0, 4'b0000);
        run_cycle();
        idle_all(); run_cycle();

        // Collision: write first, read retries and sees the new data
        set_req(0, 1'b1, 1'b1, 4, 32'h12345678, 4'b1111);
        set_req(1, 1'b1, 1'b0, 4, 32'h0, 4'b0000);
        run_cycle();
        req[0] = 1'b0; run_cycle();
        idle_all(); run_cycle();

        // Reset mid-read, then contention must favour r0 again
        set_req(0, 1'b1, 1'b1, 1, 32'h0BADF00D, 4'b1111);
        set_req(1, 1'b1, 1'b1, 7, 32'h76543210, 4'b1111);
        run_cycle();
        idle_all();
        set_req(1, 1'b1, 1'b0, 1, 32'h0, 4'b0000); run_cycle();
        idle_all(); rst_in = 1'b1; run_cycle(); rst_in = 1'b0;
        set_req(0, 1'b1, 1'b0, 1, 32'h0, 4'b0000);
        set_req(1, 1'b1, 1'b0, 7, 32'h0, 4'b0000);
        run_cycle(); run_cycle();
        idle_all(); run_cycle();

        // Random traffic with hold-until-grant requesters
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] || gnt_last[i]) begin
                    if ($urandom_range(0, 9) < 7) begin
                        set_req(i, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                                $urandom, 4'($urandom_range(0, 15)));
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
            rst_in = ($urandom_range(0, 59) == 0);
            run_cycle();
        end
        rst_in = 1'b0;
        idle_all();
        run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sdpb_arb.md
SDPB_ARB -- requirements
Module: sdpb_arb

Interface
REQ-001 SHALL have port clk, input, 1 bit: the only clock; every register updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports rN_req, input, 1 bit (N = 0, 1): requester N has a pending access.
REQ-004 SHALL have ports rN_we, input, 1 bit: 1 = write, 0 = read.
REQ-005 SHALL have ports rN_addr, input, 3 bits: word address 0-7.
REQ-006 SHALL have ports rN_wdata, input, 32 bits: write data.
REQ-007 SHALL have ports rN_wstrb, input, 4 bits: byte enables; bit i enables wdata[8i+7:8i].
REQ-008 SHALL have ports rN_gnt, output, 1 bit: access accepted this cycle (combinational from req).
REQ-009 SHALL have ports rN_rvalid, output, 1 bit: read data valid for requester N.
REQ-010 SHALL have ports rN_rdata, output, 32 bits: read data.
REQ-011 SHALL have RAM write-port outputs: ram_cea (1 bit), ram_ada (3 bits), ram_din (32 bits) and ram_byte_ena (4 bits).
REQ-012 SHALL have RAM read-port outputs: ram_ceb (1 bit), ram_adb (3 bits), ram_oce (1 bit) and ram_reset (1 bit).
REQ-013 SHALL have RAM read-data input ram_dout, 32 bits: the 8x32 dual-port RAM, bypass read mode, 1-cycle read latency.

Function
REQ-014 SHALL classify each cycle's requests into a write set and a read set by rN_we; each RAM port serves at most one request per cycle.
REQ-015 SHALL grant both requesters in the same cycle when one requests a write and the other a read, unless their addresses are equal.
REQ-016 SHALL, on a write/read address collision, grant the write only; the read stays pending with no gnt.
REQ-017 SHALL, when both requesters request the same type, grant the requester selected by a 1-bit priority register prio.
REQ-018 SHALL update prio only after a contended same-type grant: prio becomes the loser's index, effective next cycle; uncontended grants leave prio unchanged.
REQ-019 SHALL drive the write grant in the same cycle: ram_cea=1, ram_ada=addr, ram_din=wdata, ram_byte_ena=wstrb.
REQ-020 SHALL drive ram_cea=0 and ram_byte_ena=0 when no write is granted.
REQ-021 SHALL still grant a write with wstrb=0000 and assert ram_cea, so the RAM contents do not change.
REQ-022 SHALL drive the read grant in the same cycle: ram_ceb=1, ram_adb=addr.
REQ-023 SHALL drive ram_ceb=0 when no read is granted.
REQ-024 SHALL register the read-granted requester index; exactly one cycle after a read grant, only that requester's rN_rvalid=1, for one cycle.
REQ-025 SHALL drive rN_rdata=ram_dout, passed through combinationally; it is meaningful only while rN_rvalid=1.
REQ-026 SHALL tie ram_oce=1 and drive ram_reset=reset.
REQ-027 SHALL require requesters to hold req, we, addr, wdata and wstrb stable until gnt; the arbiter does not buffer requests.
REQ-028 SHALL allow back-to-back reads: a read grant may occur every cycle, with rvalid pipelined one cycle behind.
REQ-029 SHALL return the newly written data for a read granted the cycle after a write to the same address.
REQ-030 SHALL leave all grant outputs low while reset=1.

Reset
REQ-031 SHALL, on reset, set prio=0 (requester 0 wins the first contention) and clear r0_rvalid, r1_rvalid and the read-pending register.
REQ-032 SHALL suppress any rvalid still owed by a read granted before reset was asserted.

Verification
REQ-033 SHALL cover a write then read-back: r0 writes addr 3, data 0xDEADBEEF, wstrb 1111; next cycle r0 reads addr 3 -> r0_gnt each cycle, r0_rvalid one cycle after the read grant, r0_rdata=0xDEADBEEF.
REQ-034 SHALL cover a byte-masked write: location 5 holds 0x11223344; write 0xAABBCCDD with wstrb 0101 -> a read of addr 5 returns 0x11BB33DD.
REQ-035 SHALL cover same-type contention: both read, held 4 cycles, after reset -> grant order r0, r1, r0, r1, and each rvalid goes to the matching requester.
REQ-036 SHALL cover dual issue: r0 writes addr 2 while r1 reads addr 6 -> both gnt the same cycle, ram_cea=1, ram_ceb=1, and r1_rvalid the next cycle.
REQ-037 SHALL cover a collision: r0 writes addr 4 while r1 reads addr 4 -> r0_gnt=1, r1_gnt=0; the next cycle r1_gnt=1 and the read returns the new data.
REQ-038 SHALL cover reset mid-read: read granted in cycle N, reset asserted in cycle N+1 -> no rvalid asserted and prio=0 afterwards.
